// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: run/step/breakpoint controller and probe-display mux
// for the single-cycle RV32 core. The core advances only in cycles where
// cpu_en is high; the PC load and register-file/data-memory writes qualify
// on it. A debounced push-button provides single-stepping, a full-width PC
// compare provides a breakpoint, and a registered probe mux drives the
// board display.
module debug_step_ctrl #(
    parameter int XLEN       = 32,
    parameter int NCH        = 16,
    parameter int SELW       = 4,
    parameter int DISPW      = 13,
    parameter int DEB_CYCLES = 16,
    parameter int CNTW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_btn,
    input  logic                mode_run,
    input  logic                bp_en,
    input  logic [XLEN-1:0]     bp_addr,
    input  logic [XLEN-1:0]     pc,
    input  logic [NCH*XLEN-1:0] probe_bus,
    input  logic [SELW-1:0]     sel,
    input  logic                freeze,
    output logic                cpu_en,
    output logic                halted,
    output logic                bp_hit,
    output logic [CNTW-1:0]     step_count,
    output logic [DISPW-1:0]    disp
);

    // Debounce counter only needs to reach DEB_CYCLES-1.
    localparam int             DCW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

    // Controller states; the encoding is visible to existing debug tooling.
    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_STEP  = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    logic           btn_meta;
    logic           btn_sync;
    logic           btn_stable;
    logic [DCW-1:0] deb_cnt;
    logic           deb_accept;
    logic           step_pulse;
    logic           bp_match;
    logic [1:0]     state;
    logic [1:0]     state_next;

    // Padded view of the probe channels: every select code has an entry,
    // so codes at or beyond NCH read all ones without an out-of-range slice.
    logic [DISPW-1:0] chan_lsb [2**SELW];

    // Upper probe bits beyond DISPW are intentionally not displayed.
    logic unused_probe;
    assign unused_probe = ^probe_bus;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the raw, asynchronous button.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= step_btn;
            btn_sync <= btn_meta;
        end
    end

    // The synced level must disagree with the stable level for DEB_CYCLES
    // consecutive cycles; the last of those cycles is when it is accepted.
    assign deb_accept = (btn_sync != btn_stable) && (deb_cnt == DEB_LAST);

    // Pulse in the cycle the stable level goes 0->1, so a held button
    // yields exactly one step and a release yields none.
    assign step_pulse = deb_accept && btn_sync;

    // Debounce counter and accepted (stable) button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_stable <= 1'b0;
            deb_cnt    <= '0;
        end else if (btn_sync == btn_stable) begin
            deb_cnt    <= '0;
        end else if (deb_accept) begin
            btn_stable <= btn_sync;
            deb_cnt    <= '0;
        end else begin
            deb_cnt    <= deb_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Run / step / break controller
    // ------------------------------------------------------------------

    assign bp_match = bp_en && (pc == bp_addr);

    // Next-state decode; a step pulse outside HALT/BREAK is dropped.
    // NOTE: state_next gets a default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_HALT: begin
                if (mode_run)        state_next = S_RUN;
                else if (step_pulse) state_next = S_STEP;
            end
            S_STEP: begin
                state_next = mode_run ? S_RUN : S_HALT;
            end
            S_RUN: begin
                if (!mode_run)       state_next = S_HALT;
                else if (bp_match)   state_next = S_BREAK;
            end
            S_BREAK: begin
                if (!mode_run)       state_next = S_HALT;
                else if (step_pulse) state_next = S_STEP;
            end
            default: state_next = S_HALT;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HALT;
        else     state <= state_next;
    end

    // Sticky breakpoint flag: set on RUN->BREAK, cleared when a step starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit <= 1'b0;
        end else if (state == S_RUN && state_next == S_BREAK) begin
            bp_hit <= 1'b1;
        end else if (state_next == S_STEP) begin
            bp_hit <= 1'b0;
        end
    end

    // The RUN term drops out in the very cycle PC reaches the breakpoint,
    // so the instruction at bp_addr is never executed on entering BREAK.
    assign cpu_en = (state == S_STEP) ||
                    ((state == S_RUN) && mode_run && !bp_match);

    assign halted = (state == S_HALT) || (state == S_BREAK);

    // Retired-instruction counter; wraps naturally at 2^CNTW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         step_count <= '0;
        else if (cpu_en) step_count <= step_count + 1'b1;
    end

    // ------------------------------------------------------------------
    // Probe display
    // ------------------------------------------------------------------

    for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
        if (k < NCH) begin : g_live
            assign chan_lsb[k] = probe_bus[k*XLEN +: DISPW];
        end else begin : g_pad
            assign chan_lsb[k] = '1;
        end
    end

    // Registered display, held while frozen, independent of the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          disp <= '0;
        else if (!freeze) disp <= chan_lsb[sel];
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: directed scenarios for reset,
// debounce, breakpoint and stepping, a probe vector table, an asynchronous
// mid-run reset, and a randomized run against a behavioural model.
module tb_debug_step_ctrl;

    localparam int XLEN  = 32;
    localparam int NCH   = 12;
    localparam int SELW  = 4;
    localparam int DISPW = 13;
    localparam int DEB   = 4;
    localparam int CNTW  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                step_btn;
    logic                mode_run;
    logic                bp_en;
    logic [XLEN-1:0]     bp_addr;
    logic [XLEN-1:0]     pc;
    logic [NCH*XLEN-1:0] probe_bus;
    logic [SELW-1:0]     sel;
    logic                freeze;
    logic                cpu_en;
    logic                halted;
    logic                bp_hit;
    logic [CNTW-1:0]     step_count;
    logic [DISPW-1:0]    disp;

    debug_step_ctrl #(
        .XLEN(XLEN), .NCH(NCH), .SELW(SELW), .DISPW(DISPW),
        .DEB_CYCLES(DEB), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .mode_run(mode_run),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .probe_bus(probe_bus),
        .sel(sel), .freeze(freeze), .cpu_en(cpu_en), .halted(halted),
        .bp_hit(bp_hit), .step_count(step_count), .disp(disp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int k, input logic [31:0] v);
        probe_bus[k*XLEN +: XLEN] = v;
    endtask

    // Directed cycle: sample mid-cycle, then let the PC follow cpu_en.
    bit pc_auto = 1'b0;
    task automatic run_cycle(output logic en, output logic [31:0] pc_seen, output logic hit_seen);
        @(negedge clk);
        en       = cpu_en;
        pc_seen  = pc;
        hit_seen = bp_hit;
        @(posedge clk);
        #1;
        if (pc_auto && en === 1'b1) pc = pc + 32'd4;
    endtask

    typedef struct {
        logic [SELW-1:0]  sel;
        logic             freeze;
        logic [31:0]      ch3;
        logic [DISPW-1:0] exp_disp;
    } vec_t;

    vec_t vecs [10];

    // Behavioural model state for the randomized phase.
    bit              m_parked, m_at_break, m_single, m_bp_hit;
    bit              h1, h2, m_stable;
    int              m_run;
    logic [CNTW-1:0] m_count;
    logic [DISPW-1:0] m_disp;

    logic        en, hit_seen;
    logic [31:0] pc_seen;
    int          n_en, first_idx;
    logic [31:0] pc_at_step;
    logic        hit_at_step;

    initial begin
        vecs[0] = '{sel: 4'd3,  freeze: 1'b0, ch3: 32'h0000_1ABC, exp_disp: 13'h1ABC};
        vecs[1] = '{sel: 4'd3,  freeze: 1'b1, ch3: 32'h0000_0555, exp_disp: 13'h1ABC};
        vecs[2] = '{sel: 4'd0,  freeze: 1'b1, ch3: 32'h0000_0555, exp_disp: 13'h1ABC};
        vecs[3] = '{sel: 4'd15, freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h1FFF};
        vecs[4] = '{sel: 4'd3,  freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h0555};
        vecs[5] = '{sel: 4'd12, freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h1FFF};
        vecs[6] = '{sel: 4'd11, freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h0BBB};
        vecs[7] = '{sel: 4'd7,  freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h0123};
        vecs[8] = '{sel: 4'd0,  freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h0000};
        vecs[9] = '{sel: 4'd4,  freeze: 1'b0, ch3: 32'h0000_0555, exp_disp: 13'h0444};

        rst = 1'b1; step_btn = 1'b0; mode_run = 1'b0; bp_en = 1'b0;
        bp_addr = '0; pc = '0; sel = '0; freeze = 1'b0;
        for (int k = 0; k < NCH; k++) set_chan(k, 32'hA5A5_0000 | (k * 32'h111));
        set_chan(7, 32'hFFFF_E123);
        repeat (3) tick();

        // ---- Reset state and idle HALT ----
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_step_count", step_count, 0);
        check("rst_disp", disp, 0);
        rst = 1'b0;
        n_en = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle(en, pc_seen, hit_seen);
            if (en === 1'b1) n_en++;
        end
        check("idle_cpu_en_cycles", n_en, 0);
        check("idle_halted", halted, 1);
        check("idle_step_count", step_count, 0);
        check("idle_disp", disp, 0);

        // ---- Bouncing press, then hold: one step 6 cycles after final rise ----
        n_en = 0; first_idx = -1;
        for (int j = 0; j < 34; j++) begin
            step_btn = (j < 4) ? (j % 2 == 0) : (j < 24);
            run_cycle(en, pc_seen, hit_seen);
            if (en === 1'b1) begin
                n_en++;
                if (first_idx < 0) first_idx = j;
            end
        end
        check("deb_pulse_count", n_en, 1);
        check("deb_pulse_index", first_idx, 10);
        check("deb_step_count", step_count, 1);
        check("deb_back_halted", halted, 1);

        // ---- Free run into a breakpoint at 0x10 ----
        rst = 1'b1;
        tick();
        mode_run = 1'b1; bp_en = 1'b1; bp_addr = 32'h10; pc = '0; pc_auto = 1'b1;
        rst = 1'b0;
        n_en = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(en, pc_seen, hit_seen);
            if (en === 1'b1) n_en++;
        end
        check("bp_enable_cycles", n_en, 4);
        check("bp_pc_stop", pc, 32'h10);
        check("bp_cpu_en_at_bp", cpu_en, 0);
        check("bp_hit_set", bp_hit, 1);
        check("bp_halted", halted, 1);
        check("bp_step_count", step_count, 4);

        // ---- Step out of BREAK, then RUN resumes ----
        n_en = 0; first_idx = -1; pc_at_step = '0; hit_at_step = 1'b1;
        for (int j = 0; j < 30; j++) begin
            step_btn = (j < 12);
            run_cycle(en, pc_seen, hit_seen);
            if (en === 1'b1) begin
                n_en++;
                if (first_idx < 0) begin
                    first_idx = j; pc_at_step = pc_seen; hit_at_step = hit_seen;
                end
            end
        end
        check("brk_step_index", first_idx, 6);
        check("brk_step_pc", pc_at_step, 32'h10);
        check("brk_step_bp_hit_clr", hit_at_step, 0);
        check("brk_enable_cycles", n_en, 24);
        check("brk_step_count", step_count, 28);
        check("brk_pc_after", pc, 32'h70);
        check("brk_running", halted, 0);

        // ---- Probe mux table (controller keeps running at pc 0x70) ----
        pc_auto = 1'b0;
        for (int v = 0; v < 10; v++) begin
            sel = vecs[v].sel;
            freeze = vecs[v].freeze;
            set_chan(3, vecs[v].ch3);
            tick();
            check($sformatf("probe_vec%0d", v), disp, vecs[v].exp_disp);
        end

        // ---- Asynchronous reset between edges, mid-RUN ----
        check("pre_rst_cpu_en", cpu_en, 1);
        check("pre_rst_step_count", step_count, 38);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cpu_en", cpu_en, 0);
        check("async_rst_step_count", step_count, 0);
        check("async_rst_disp", disp, 0);
        check("async_rst_halted", halted, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_still_halt", halted, 1);
        tick();
        check("post_rst_run_halted", halted, 0);
        check("post_rst_run_cpu_en", cpu_en, 1);
        check("post_rst_step_count", step_count, 0);

        // ---- Randomized run against the behavioural model ----
        rst = 1'b1; step_btn = 1'b0; mode_run = 1'b0; bp_en = 1'b1;
        bp_addr = 32'h10; pc = '0; freeze = 1'b0; sel = '0;
        tick();
        m_parked = 1'b1; m_at_break = 1'b0; m_single = 1'b0; m_bp_hit = 1'b0;
        h1 = 1'b0; h2 = 1'b0; m_stable = 1'b0; m_run = 0; m_count = '0; m_disp = '0;
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit          bpm, exp_en, running, pulse;
            int          run_cur;
            logic [31:0] next_pc;

            if ($urandom_range(5) == 0)  step_btn = ~step_btn;
            if ($urandom_range(39) == 0) mode_run = ~mode_run;
            if ($urandom_range(49) == 0) bp_en = ~bp_en;
            if ($urandom_range(99) == 0) begin
                case ($urandom_range(3))
                    0: bp_addr = 32'h10;
                    1: bp_addr = 32'h20;
                    2: bp_addr = 32'h3C;
                    default: bp_addr = 32'h00;
                endcase
            end
            sel = SELW'($urandom_range(15));
            freeze = ($urandom_range(3) == 0);
            for (int k = 0; k < NCH; k++) set_chan(k, $urandom);

            // Expected outputs for this cycle.
            bpm     = bp_en && (pc == bp_addr);
            running = !m_parked && !m_single;
            exp_en  = m_single || (running && mode_run && !bpm);
            run_cur = (h2 != m_stable) ? m_run + 1 : 0;
            pulse   = (run_cur == DEB) && h2;

            @(negedge clk);
            check("rand_cpu_en", cpu_en, exp_en);
            check("rand_halted", halted, m_parked);
            check("rand_bp_hit", bp_hit, m_bp_hit);
            check("rand_step_count", step_count, m_count);
            check("rand_disp", disp, m_disp);

            // Advance the model by one clock.
            if (run_cur == DEB) begin
                m_stable = h2;
                m_run = 0;
            end else begin
                m_run = run_cur;
            end
            h2 = h1;
            h1 = step_btn;
            if (exp_en) m_count = m_count + 1'b1;
            if (!freeze) m_disp = (sel < NCH) ? probe_bus[sel*XLEN +: DISPW] : '1;

            if (m_single) begin
                m_single = 1'b0;
                m_parked = !mode_run;
            end else if (m_parked) begin
                if (!m_at_break) begin
                    if (mode_run) begin
                        m_parked = 1'b0;
                    end else if (pulse) begin
                        m_parked = 1'b0; m_single = 1'b1; m_bp_hit = 1'b0;
                    end
                end else begin
                    if (!mode_run) begin
                        m_at_break = 1'b0;
                    end else if (pulse) begin
                        m_parked = 1'b0; m_at_break = 1'b0; m_single = 1'b1; m_bp_hit = 1'b0;
                    end
                end
            end else begin
                if (!mode_run) begin
                    m_parked = 1'b1;
                end else if (bpm) begin
                    m_parked = 1'b1; m_at_break = 1'b1; m_bp_hit = 1'b1;
                end
            end

            next_pc = pc;
            if (exp_en) begin
                next_pc = (pc + 32'd4) & 32'h3F;
                if ($urandom_range(29) == 0) next_pc = 32'($urandom_range(15)) * 32'd4;
            end

            @(posedge clk);
            #1;
            pc = next_pc;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
